// File: rtl/rca_seq_ctrl_pkg.sv
// Shared definitions for the word-serial add/subtract controller:
// sequencer state encoding and width helpers.
package rca_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice index width: ceil(log2 k), never narrower than one bit (k = 1 is legal).
  function automatic int idx_width(input int k);
    int w;
    if (k > 1) begin
      w = $clog2(k);
    end else begin
      w = 1;
    end
    return w;
  endfunction

  // Two's-complement overflow from the sign bits of both addends and the result.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    logic ovf;
    ovf = (a_msb ~^ b_msb) & (s_msb ^ a_msb);
    return ovf;
  endfunction

endpackage

// File: rtl/RCA_param.sv
// Parameterised N-bit ripple-carry adder: one full-adder cell per bit,
// carry rippling from bit 0 upwards.
module RCA_param #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] s_o,
  output logic         c_o
);

  logic [N:0] carry_s;

  // Ripple chain: each cell consumes the carry produced by the cell below it.
  always_comb begin
    carry_s    = {(N+1){1'b0}};
    s_o        = {N{1'b0}};
    carry_s[0] = c_i;
    for (int i = 0; i < N; i++) begin
      s_o[i]       = a_i[i] ^ b_i[i] ^ carry_s[i];
      carry_s[i+1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o = carry_s[N];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Word-serial W = N*K bit add/subtract: one shared N-bit ripple-carry adder
// walks the operand slices LSB first, linked by a carry register.
module rca_seq_ctrl
  import rca_seq_ctrl_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N*K-1:0] sum,
  output logic         carry_out,
  output logic         overflow
);

  localparam int W  = N * K;
  localparam int IW = idx_width(K);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   work_q, work_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           sub_q, sub_d;
  logic           c_q, c_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           co_q, co_d;
  logic           ov_q, ov_d;

  logic [N-1:0]   a_sl_s;
  logic [N-1:0]   b_sl_s;
  logic [N-1:0]   rs_s;
  logic           rc_s;

  // Slice select for the shared adder; B is inverted here for subtraction.
  always_comb begin
    a_sl_s = a_q[idx_q*N +: N];
    if (sub_q) begin
      b_sl_s = ~b_q[idx_q*N +: N];
    end else begin
      b_sl_s = b_q[idx_q*N +: N];
    end
  end

  RCA_param #(
    .N (N)
  ) u_rca (
    .a_i (a_sl_s),
    .b_i (b_sl_s),
    .c_i (c_q),
    .s_o (rs_s),
    .c_o (rc_s)
  );

  // Sequencer next state, operand capture, slice write-back and result load.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    c_d     = c_q;
    idx_d   = idx_q;
    work_d  = work_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          c_d     = sub;
          idx_d   = {IW{1'b0}};
          work_d  = {W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        work_d[idx_q*N +: N] = rs_s;
        c_d                  = rc_s;
        if (idx_q == IW'(K - 1)) begin
          state_d = DONE;
          idx_d   = {IW{1'b0}};
          sum_d   = work_d;
          co_d    = rc_s;
          ov_d    = add_overflow(a_q[W-1], b_q[W-1] ^ sub_q, work_d[W-1]);
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset clears everything, aborting any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      work_q  <= {W{1'b0}};
      sum_q   <= {W{1'b0}};
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      idx_q   <= {IW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl (N = 4, K = 4): table vectors, random
// operations against an arithmetic model, ignored/back-to-back starts, reset abort.
module tb_rca_seq_ctrl;

  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  rca_seq_ctrl #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic s_i, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W:0]   full;
    logic [W-1:0] be;
    exp_t         e;
    be   = s_i ? ~bv : bv;
    full = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, s_i};
    e.s  = full[W-1:0];
    e.co = full[W];
    e.ov = (av[W-1] == be[W-1]) && (full[W-1] != av[W-1]);
    return e;
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the start edge. Returns at
  // the negedge of cycle t+1 with operands scrambled to prove they were latched.
  task automatic issue(input logic s_i, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit push, input exp_t e);
    start = 1'b1;
    sub   = s_i;
    a     = av;
    b     = bv;
    if (push) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    sub   = ~s_i;
  endtask

  // Waits for done (bounded), checks latency/busy span, then scores the result.
  task automatic await_done(input bit inject, input string tag);
    int   lat;
    int   bc;
    exp_t e;
    lat = 1;
    bc  = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bc++;
      if (inject && lat <= 3) begin
        start = lat[0];
        a     = W'($urandom);
        b     = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {15'd0, done}, 16'd1);
    check({tag, "_latency"}, W'(lat), W'(K + 1));
    check({tag, "_busy_cycles"}, W'(bc), W'(K));
    check({tag, "_busy_in_done"}, {15'd0, busy}, 16'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_sum"}, sum, e.s);
      check({tag, "_carry_out"}, {15'd0, carry_out}, {15'd0, e.co});
      check({tag, "_overflow"}, {15'd0, overflow}, {15'd0, e.ov});
    end
  endtask

  initial begin
    exp_t e;
    exp_t e_first;
    int   dcnt;
    logic s_r;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;

    vecs[0] = '{sub: 1'b0, a: 16'h1234, b: 16'h0FFF, e: '{s: 16'h2233, co: 1'b0, ov: 1'b0}};
    vecs[1] = '{sub: 1'b0, a: 16'hFFFF, b: 16'h0001, e: '{s: 16'h0000, co: 1'b1, ov: 1'b0}};
    vecs[2] = '{sub: 1'b1, a: 16'h8000, b: 16'h0001, e: '{s: 16'h7FFF, co: 1'b1, ov: 1'b1}};
    vecs[3] = '{sub: 1'b1, a: 16'h0000, b: 16'h0001, e: '{s: 16'hFFFF, co: 1'b0, ov: 1'b0}};
    vecs[4] = '{sub: 1'b1, a: 16'h1234, b: 16'h1234, e: '{s: 16'h0000, co: 1'b1, ov: 1'b0}};
    vecs[5] = '{sub: 1'b0, a: 16'h7FFF, b: 16'h7FFF, e: '{s: 16'hFFFE, co: 1'b0, ov: 1'b1}};

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_sum", sum, 16'h0000);
    check("rst_carry_out", {15'd0, carry_out}, 16'd0);
    check("rst_overflow", {15'd0, overflow}, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].sub, vecs[i].a, vecs[i].b, 1'b1, vecs[i].e);
      await_done(1'b0, "tbl");
      @(negedge clk);
      check("tbl_done_pulse", {15'd0, done}, 16'd0);
      check("tbl_sum_hold", sum, vecs[i].e.s);
    end

    for (int i = 0; i < 4; i++) begin
      s_r = 1'($urandom);
      a_r = W'($urandom);
      b_r = W'($urandom);
      e   = model(s_r, a_r, b_r);
      issue(s_r, a_r, b_r, 1'b1, e);
      await_done(1'b0, "rnd");
      @(negedge clk);
    end

    // Starts pulsed during RUN with other operands must be dropped.
    e_first = model(1'b0, 16'h1111, 16'h2222);
    issue(1'b0, 16'h1111, 16'h2222, 1'b1, e_first);
    await_done(1'b1, "ign");
    @(negedge clk);
    check("ign_no_second_op", {15'd0, busy}, 16'd0);
    repeat (K + 2) @(negedge clk);
    check("ign_no_extra_done", {15'd0, done}, 16'd0);

    // Start held in the DONE cycle is accepted back-to-back.
    issue(1'b0, 16'h00FF, 16'h0F01, 1'b1, model(1'b0, 16'h00FF, 16'h0F01));
    await_done(1'b0, "b2b_first");
    issue(1'b1, 16'h8000, 16'h0001, 1'b1, model(1'b1, 16'h8000, 16'h0001));
    await_done(1'b0, "b2b_second");
    @(negedge clk);

    // Reset two cycles into RUN clears outputs at once and yields no done.
    issue(1'b0, 16'h5555, 16'h1111, 1'b0, e);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_done", {15'd0, done}, 16'd0);
    check("abort_sum", sum, 16'h0000);
    check("abort_carry_out", {15'd0, carry_out}, 16'd0);
    check("abort_overflow", {15'd0, overflow}, 16'd0);
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    check("abort_no_activity", W'(dcnt), 16'd0);

    issue(1'b0, 16'h7FFF, 16'h0001, 1'b1, '{s: 16'h8000, co: 1'b0, ov: 1'b1});
    await_done(1'b0, "post_abort");
    check("sb_drained", W'(sb.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
